// File: rtl/byte_memory.sv
// byte_memory: single-port byte-strobed data memory with request/response handshake and hardware clear.
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset (starts clear sequence)
//   req_valid/req_ready         - request handshake; accept when both high
//   req_write/addr/wdata/be     - request payload (byte address, per-byte enables)
//   rsp_valid/rsp_rdata/rsp_error - one-cycle response pulse per accepted request
//   busy                        - clear sequence in progress
//   err_count                   - saturating count of error responses
module byte_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic                    busy,
    output logic [7:0]              err_count
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         clr_idx_q, clr_idx_d;
    logic                  ready_q, ready_d, busy_q, busy_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IW-1:0]         widx;
    logic                  accept, req_err, wr_en;

    // Range check uses the full shifted address so high address bits never alias into the array.
    assign word_addr = req_addr >> OFF;
    assign widx      = word_addr[IW-1:0];
    assign accept    = req_valid && ready_q;
    assign req_err   = (|(req_addr & ADDR_WIDTH'(NB - 1))) || (word_addr >= ADDR_WIDTH'(DEPTH));
    assign wr_en     = accept && req_write && !req_err;

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IW'(DEPTH - 1)) begin
                state_d = READY;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        end
        rsp_valid_d = accept;
        rsp_error_d = accept ? req_err : rsp_error_q;
        rsp_rdata_d = accept ? ((req_write || req_err) ? '0 : mem_q[widx]) : rsp_rdata_q;
        err_count_d = err_count_q + 8'(accept && req_err && err_count_q != 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_count_q <= err_count_d;
        end
    end

    // Array is not reset directly; the clear sequencer zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR)
                mem_q[clr_idx_q] <= '0;
            else if (wr_en)
                for (int b = 0; b < NB; b++)
                    if (req_be[b]) mem_q[widx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_byte_memory.sv
// tb_byte_memory: table-driven scoreboard bench for byte_memory.
module tb_byte_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[12];

    byte_memory #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each response popped in order and compared against the expectation pushed at drive time.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
            end
        end
    end

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic ee, input logic [31:0] er);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        e.err     = ee;
        e.rdata   = er;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = $urandom_range(0, 1);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h7C, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEAA};
        vecs[5]  = '{1'b0, 32'h12, 32'h0,        4'h0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h14, 32'h12345678, 4'h0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h14, 32'h0,        4'h0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h18, 32'h11223344, 4'h6, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h18, 32'h0,        4'h0, 1'b0, 32'h00223300};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'b0, rsp_error}, 32'd0);
        chk("reset_err_count", {24'b0, err_count}, 32'd0);
        reset = 1'b0;
        wait_ready(n);
        chk("clear_edges", n, 32);
        chk("busy_after_clear", {31'b0, busy}, 32'd0);

        foreach (vecs[i])
            drive(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].err, vecs[i].rdata);
        idle(2);
        chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("hold_rsp_rdata", rsp_rdata, 32'h00223300);
        chk("err_count_two", {24'b0, err_count}, 32'd2);

        for (int i = 0; i < 8; i++) drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, 32'h1000 + 32'(i));
        idle(1);
        chk("b2b_drained", exp_q.size(), 0);

        drive(1'b0, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 32'h0);
        idle(1);
        chk("err_count_high_addr", {24'b0, err_count}, 32'd3);

        for (int i = 0; i < 300; i++) drive(i[0], 32'(4 * (i % 32) + 1 + (i % 3)), $urandom, 4'hF, 1'b1, 32'h0);
        idle(1);
        chk("err_count_sat", {24'b0, err_count}, 32'd255);
        chk("sat_drained", exp_q.size(), 0);
        drive(1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h1001);
        idle(1);
        chk("word1_after_errors", rsp_rdata, 32'h1001);

        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midreset_busy", {31'b0, busy}, 32'd1);
        chk("midreset_ready", {31'b0, req_ready}, 32'd0);
        chk("midreset_err_count", {24'b0, err_count}, 32'd0);
        chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        wait_ready(n);
        chk("reclear_edges", n, 32);
        drive(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(2);
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
